// File: rtl/pll_config_apb.sv
// APB-programmable PLL divider/multiplier configuration with reset and relock sequencing.
// Optional lock-timeout detection is enabled by defining PLL_CONFIG_LOCK_TIMEOUT_EN.
module pll_config_apb #(
    parameter int XLEN         = 32,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [XLEN-1:0]   PWDATA,
    input  logic [XLEN/8-1:0] PSTRB,
    output logic [XLEN-1:0]   PRDATA,
    output logic              PREADY,
    input  logic              PLLLocked,
    output logic              PLLReset,
    output logic [7:0]        PLLMult,
    output logic [5:0]        PLLDiv,
    output logic [6:0]        PLLOutDiv
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] lockcnt_q, lockcnt_d;
    logic [7:0]  sh_mult_q, sh_mult_d;
    logic [5:0]  sh_div_q, sh_div_d;
    logic [6:0]  sh_odiv_q, sh_odiv_d;
    logic [7:0]  ap_mult_q, ap_mult_d;
    logic [5:0]  ap_div_q, ap_div_d;
    logic [6:0]  ap_odiv_q, ap_odiv_d;
    logic        err_q, err_d;
    logic        pll_reset_q, pll_reset_d;
    logic        sync1_q, sync2_q;

    logic        wr_en, wr_cfg, wr_ctrl, wr_status, go;
    logic        lock_s, busy;
    logic [5:0]  word;
    logic [31:0] rdata;
    logic        unused_bits;

    assign word      = PADDR[7:2];
    assign wr_en     = PSEL & PENABLE & PWRITE;
    assign wr_cfg    = wr_en && (word == 6'd0);
    assign wr_ctrl   = wr_en && (word == 6'd1);
    assign wr_status = wr_en && (word == 6'd2);
    assign go        = wr_ctrl & PSTRB[0] & PWDATA[0];
    assign lock_s    = sync2_q;
    assign busy      = (state_q != S_IDLE);

    assign PREADY    = 1'b1;
    assign PLLReset  = pll_reset_q;
    assign PLLMult   = ap_mult_q;
    assign PLLDiv    = ap_div_q;
    assign PLLOutDiv = ap_odiv_q;

    assign unused_bits = ^{PADDR[1:0], PWDATA, PSTRB};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lockcnt_d = lockcnt_q;
        sh_mult_d = sh_mult_q;
        sh_div_d  = sh_div_q;
        sh_odiv_d = sh_odiv_q;
        ap_mult_d = ap_mult_q;
        ap_div_d  = ap_div_q;
        ap_odiv_d = ap_odiv_q;
        err_d     = err_q;

        if (wr_cfg) begin
            if (PSTRB[0]) sh_mult_d = PWDATA[7:0];
            if (PSTRB[1]) sh_div_d  = PWDATA[13:8];
            if (PSTRB[2]) sh_odiv_d = PWDATA[22:16];
        end

`ifdef PLL_CONFIG_LOCK_TIMEOUT_EN
        if (wr_status && PSTRB[0] && PWDATA[2]) err_d = 1'b0;
`else
        err_d = 1'b0;
`endif

        // Timeout set is evaluated after the W1C above so that set wins.
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    ap_mult_d = sh_mult_q;
                    ap_div_d  = sh_div_q;
                    ap_odiv_d = sh_odiv_q;
                    err_d     = 1'b0;
                    cnt_d     = 16'(RST_CYCLES);
                    state_d   = S_RST;
                end
            end
            S_RST: begin
                if (cnt_q <= 16'd1) begin
                    cnt_d   = 16'(LOCK_TIMEOUT);
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    if (lockcnt_q != 16'hFFFF) lockcnt_d = lockcnt_q + 16'd1;
                    state_d = S_IDLE;
                end
`ifdef PLL_CONFIG_LOCK_TIMEOUT_EN
                else if (cnt_q <= 16'd1) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        pll_reset_d = (state_d == S_RST);
    end

    always_comb begin
        rdata = '0;
        if (PSEL) begin
            case (word)
                6'd0:    rdata = {9'd0, sh_odiv_q, 2'd0, sh_div_q, sh_mult_q};
                6'd2:    rdata = {26'd0, state_q, 1'b0, err_q, lock_s, busy};
                6'd3:    rdata = {16'd0, lockcnt_q};
                default: rdata = '0;
            endcase
        end
        PRDATA        = '0;
        PRDATA[31:0]  = rdata;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lockcnt_q   <= '0;
            sh_mult_q   <= 8'd20;
            sh_div_q    <= 6'd1;
            sh_odiv_q   <= 7'd2;
            ap_mult_q   <= 8'd20;
            ap_div_q    <= 6'd1;
            ap_odiv_q   <= 7'd2;
            err_q       <= 1'b0;
            pll_reset_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lockcnt_q   <= lockcnt_d;
            sh_mult_q   <= sh_mult_d;
            sh_div_q    <= sh_div_d;
            sh_odiv_q   <= sh_odiv_d;
            ap_mult_q   <= ap_mult_d;
            ap_div_q    <= ap_div_d;
            ap_odiv_q   <= ap_odiv_d;
            err_q       <= err_d;
            pll_reset_q <= pll_reset_d;
            sync1_q     <= PLLLocked;
            sync2_q     <= sync1_q;
        end
    end

endmodule

// File: tb/tb_pll_config_apb.sv
// Directed self-checking bench for pll_config_apb with a cycle-indexed behavioural model.
// Exercises the timeout path only when PLL_CONFIG_LOCK_TIMEOUT_EN is defined.
module tb_pll_config_apb;

    localparam int XLEN    = 32;
    localparam int RST_CYC = 16;
    localparam int LTO     = 8;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PLLLocked = 1'b0;
    logic        PLLReset;
    logic [7:0]  PLLMult;
    logic [5:0]  PLLDiv;
    logic [6:0]  PLLOutDiv;

    pll_config_apb #(.XLEN(XLEN), .RST_CYCLES(RST_CYC), .LOCK_TIMEOUT(LTO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PLLLocked(PLLLocked), .PLLReset(PLLReset), .PLLMult(PLLMult), .PLLDiv(PLLDiv),
        .PLLOutDiv(PLLOutDiv)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Model: shadow/applied config, reset window [rst_from, rst_from+RST_CYC) in edge indices.
    int m_mult = 20, m_div = 1, m_odiv = 2;
    int s_mult = 20, s_div = 1, s_odiv = 2;
    int m_lockcnt = 0;
    bit m_err = 0, m_busy = 0, m_lk = 0, chk_en = 0;
    int rst_from = -1000;
    int rst_len = 0, last_pulse = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_rst();
        return (cyc >= rst_from) && (cyc < rst_from + RST_CYC);
    endfunction

    function automatic logic [1:0] m_state();
        if (!m_busy) return 2'd0;
        if (exp_rst()) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] m_status();
        logic [1:0] st;
        st = m_state();
        return {26'd0, st, 1'b0, m_err, m_lk, m_busy};
    endfunction

    always @(negedge PCLK) begin
        if (chk_en) begin
            check_val("pllreset", {31'd0, PLLReset}, {31'd0, exp_rst()});
            check_val("pllmult", {24'd0, PLLMult}, m_mult);
            check_val("plldiv", {26'd0, PLLDiv}, m_div);
            check_val("plloutdiv", {25'd0, PLLOutDiv}, m_odiv);
            check_val("pready", {31'd0, PREADY}, 32'd1);
        end
        if (PLLReset === 1'b1) rst_len++;
        else if (rst_len != 0) begin
            last_pulse = rst_len;
            rst_len = 0;
        end
    end

    task automatic wait_until(input int e);
        int guard = 0;
        while (cyc < e && guard < 20000) begin
            @(posedge PCLK); #1;
            guard++;
        end
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s, input int g);
        case (addr[7:2])
            6'd0: begin
                if (s[0]) s_mult = int'(d[7:0]);
                if (s[1]) s_div  = int'(d[13:8]);
                if (s[2]) s_odiv = int'(d[22:16]);
            end
            6'd1: if (d[0] && s[0] && !m_busy) begin
                m_mult = s_mult; m_div = s_div; m_odiv = s_odiv;
                m_err = 0; m_busy = 1; rst_from = g;
            end
            6'd2: if (s[0] && d[2]) m_err = 0;
            default: ;
        endcase
    endtask

    task automatic apb_setup(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s, input logic wr);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = d; PSTRB = s;
        @(posedge PCLK); #1;
        PENABLE = 1;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s);
        apb_setup(addr, d, s, 1'b1);
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        model_write(addr, d, s, cyc);
    endtask

    task automatic apb_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
        apb_setup(addr, '0, '0, 1'b0);
        #3 check_val(name, PRDATA, exp);
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic read_status(input string name);
        apb_setup(8'h08, '0, '0, 1'b0);
        #3 check_val(name, PRDATA, m_status());
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic do_reset(input int n);
        @(posedge PCLK); #1;
        chk_en = 0; PRESETn = 0;
        repeat (n) begin @(posedge PCLK); #1; end
        PRESETn = 1;
        m_mult = 20; m_div = 1; m_odiv = 2; s_mult = 20; s_div = 1; s_odiv = 2;
        m_lockcnt = 0; m_err = 0; m_busy = 0; m_lk = 0; rst_from = -1000;
        chk_en = 1;
    endtask

    // Lock asserted n cycles after PLLReset falls; busy must drop on the third edge after.
    task automatic do_lock(input int n);
        int f;
        f = rst_from + RST_CYC;
        wait_until(f + n);
        PLLLocked = 1; PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h08;
        wait_until(f + n + 2);
        #3 check_val("status_lock_seen", PRDATA, 32'h23);
        wait_until(f + n + 3);
        #3 check_val("status_after_lock", PRDATA, 32'h02);
        m_busy = 0; m_lockcnt++;
        PLLLocked = 0; PSEL = 0;
        wait_until(cyc + 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f, g;
        do_reset(3);

        // Reset state
        apb_read(8'h00, 32'h0002_0114, "cfg_reset");
        apb_read(8'h08, 32'h0, "status_reset");
        apb_read(8'h04, 32'h0, "ctrl_reset");
        apb_read(8'h0C, 32'h0, "lockcnt_reset");
        check_val("mult_reset_lit", {24'd0, PLLMult}, 32'd20);
        check_val("pllreset_reset_lit", {31'd0, PLLReset}, 32'd0);

        // Configure and relock
        apb_write(8'h00, 32'h0003_0232, 4'hF);
        apb_read(8'h00, 32'h0003_0232, "cfg_readback");
        apb_write(8'h04, 32'h1, 4'hF);
        read_status("status_in_rst");
        check_val("status_rst_model_lit", m_status(), 32'h11);
        f = rst_from + RST_CYC;
        wait_until(f + 1);
        read_status("status_in_wait");
        apb_read(8'h04, 32'h0, "ctrl_reads_zero");
        do_lock(10);
        check_val("mult_after_go", {24'd0, PLLMult}, 32'd50);
        check_val("div_after_go", {26'd0, PLLDiv}, 32'd2);
        check_val("odiv_after_go", {25'd0, PLLOutDiv}, 32'd3);
        check_val("pulse_len_1", last_pulse, 32'd16);
        apb_read(8'h0C, 32'd1, "lockcnt_1");

        // Byte-masked CFG write leaves applied outputs alone
        apb_write(8'h00, 32'h0000_00FF, 4'b0001);
        apb_read(8'h00, 32'h0003_02FF, "cfg_strb_byte0");
        apb_write(8'h00, 32'hFFFF_FFFF, 4'b0000);
        apb_read(8'h00, 32'h0003_02FF, "cfg_strb_none");
        check_val("mult_before_go", {24'd0, PLLMult}, 32'd50);

        // GO during RST is ignored
        apb_write(8'h04, 32'h1, 4'hF);
        g = rst_from;
        apb_write(8'h04, 32'h1, 4'hF);
        check_val("second_go_ignored", rst_from, g);
        do_lock(10);
        check_val("pulse_len_2", last_pulse, 32'd16);
        check_val("mult_after_go2", {24'd0, PLLMult}, 32'd255);
        apb_read(8'h0C, 32'd2, "lockcnt_2");
        apb_write(8'h0C, 32'h0, 4'hF);
        apb_read(8'h0C, 32'd2, "lockcnt_ro");
        apb_read(8'h10, 32'h0, "unmapped_read");
        apb_write(8'h10, 32'hFFFF_FFFF, 4'hF);
        apb_read(8'h00, 32'h0003_02FF, "unmapped_write");

        // Synchronized lock visible in STATUS while idle
        PLLLocked = 1;
        wait_until(cyc + 3);
        m_lk = 1;
        read_status("status_lock_idle");
        PLLLocked = 0;
        wait_until(cyc + 3);
        m_lk = 0;
        read_status("status_lock_dropped");

`ifdef PLL_CONFIG_LOCK_TIMEOUT_EN
        apb_write(8'h04, 32'h1, 4'hF);
        f = rst_from + RST_CYC + LTO;
        wait_until(f - 1);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h08;
        #3 check_val("status_before_timeout", PRDATA, 32'h21);
        wait_until(f);
        #3 check_val("status_timeout", PRDATA, 32'h04);
        PSEL = 0;
        m_busy = 0; m_err = 1;
        read_status("status_timeout_model");
        apb_write(8'h08, 32'h4, 4'hF);
        apb_read(8'h08, 32'h0, "status_w1c");
`endif

        // Reset asserted mid-WAIT
        apb_write(8'h04, 32'h1, 4'hF);
        wait_until(rst_from + RST_CYC + 3);
        do_reset(1);
        wait_until(cyc + 2);
        apb_read(8'h0C, 32'h0, "lockcnt_after_reset");
        apb_read(8'h00, 32'h0002_0114, "cfg_after_reset");
        apb_read(8'h08, 32'h0, "status_after_reset");
        check_val("mult_after_reset", {24'd0, PLLMult}, 32'd20);
        check_val("div_after_reset", {26'd0, PLLDiv}, 32'd1);
        check_val("odiv_after_reset", {25'd0, PLLOutDiv}, 32'd2);
        check_val("pllreset_after_reset", {31'd0, PLLReset}, 32'd0);

        wait_until(cyc + 2);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_config_apb.md
PLL_CONFIG_APB -- requirements
Module: pll_config_apb

Interface
- REQ-001: Parameter XLEN, default 32; APB data width, 32 or 64.
- REQ-002: Parameter RST_CYCLES, default 16; cycles PLLReset is held per reconfiguration, range 1..255.
- REQ-003: Parameter LOCK_TIMEOUT, default 4096; cycles allowed for lock before error, range 1..65535.
- REQ-004: PCLK  in  1  single clock for all logic.
- REQ-005: PRESETn  in  1  reset; synchronous and active-low.
- REQ-006: PSEL, PENABLE, PWRITE  in  1 each  APB select, access phase, write.
- REQ-007: PADDR  in  8  byte address; bits [1:0] ignored.
- REQ-008: PWDATA  in  XLEN  write data; only bits [31:0] used.
- REQ-009: PSTRB  in  XLEN/8  byte strobes; only bits [3:0] used.
- REQ-010: PRDATA  out  XLEN  read data; upper bits zero when XLEN=64.
- REQ-011: PREADY  out  1  always 1; zero wait states.
- REQ-012: PLLLocked  in  1  asynchronous lock indication from PLL macro.
- REQ-013: PLLReset  out  1  active-high PLL reset.
- REQ-014: PLLMult  out  8, PLLDiv  out  6, PLLOutDiv  out  7  applied divider settings.

Function
- REQ-015: APB write takes effect on the cycle PSEL&PENABLE&PWRITE; read data is combinational from PADDR whenever PSEL is high.
- REQ-016: Register map: 0x00 CFG (shadow: [7:0] mult, [13:8] div, [22:16] odiv); 0x04 CTRL ([0] GO, write-1-to-start, reads 0); 0x08 STATUS ([0] busy, [1] locked-sync, [2] timeout-err W1C, [5:4] state); 0x0C LOCKCNT (16-bit count of successful relocks, read-only, saturates at 0xFFFF).
- REQ-017: CFG writes are byte-masked by PSTRB and accepted at any time, including while busy; they never alter the applied outputs directly.
- REQ-018: Unmapped addresses read 0; writes to them and to read-only fields have no effect.
- REQ-019: PLLLocked passes through a 2-flop synchronizer; all FSM decisions and STATUS[1] use the synchronized value.
- REQ-020: FSM states IDLE(0), RST(1), WAIT(2).
- REQ-021: IDLE: GO=1 loads applied outputs from shadow CFG, clears STATUS[2], loads a counter with RST_CYCLES, goes to RST next cycle.
- REQ-022: GO written while not IDLE is ignored.
- REQ-023: RST: PLLReset=1; counter decrements each cycle; after exactly RST_CYCLES cycles in RST, transitions to WAIT with counter loaded with LOCK_TIMEOUT.
- REQ-024: WAIT: PLLReset=0; synchronized lock=1 returns to IDLE and increments LOCKCNT.
- REQ-025: Lock and timeout expiry in the same cycle resolve as lock.
- REQ-026: Busy (STATUS[0]) is 1 in RST and WAIT, 0 in IDLE.
- REQ-027: Simultaneous W1C of STATUS[2] and timeout set in the same cycle: set wins.

Reset
- REQ-028: Synchronous reset values: state IDLE, PLLReset=0, shadow and applied mult=20, div=1, odiv=2, STATUS[2]=0, LOCKCNT=0, synchronizer flops 0, counter 0.
- REQ-029: Reset asserted mid-sequence returns to IDLE on the next edge with PLLReset=0; no lock is counted.

Configuration
- REQ-030: Macro PLL_CONFIG_LOCK_TIMEOUT_EN defined: in WAIT, the counter decrements; on reaching 0 without lock, the block sets STATUS[2]=1 and returns to IDLE with PLLReset=0.
- REQ-031: PLL_CONFIG_LOCK_TIMEOUT_EN undefined: WAIT exits only on lock, STATUS[2] reads 0, and LOCK_TIMEOUT is unused.

Verification
- REQ-032: Reset, then read 0x00 -> 0x0002_0114; read 0x08 -> 0; outputs 20/1/2; PLLReset=0.
- REQ-033: Write CFG 0x0003_0232, GO; PLLLocked rises 10 cycles after PLLReset falls -> PLLReset high exactly 16 cycles; outputs 50/2/3; LOCKCNT=1; busy clears 2-3 cycles after lock.
- REQ-034: Write CFG with PSTRB=0b0001, data 0xFF -> CFG mult=0xFF, other fields unchanged; applied outputs unchanged until GO.
- REQ-035: With PLL_CONFIG_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=8, GO with PLLLocked held 0 -> STATUS=0x4 after 8 WAIT cycles; write 0x4 to 0x08 -> STATUS=0.
- REQ-036: Second GO written during RST -> ignored; PLLReset pulse stays 16 cycles; LOCKCNT increments by 1 only.
- REQ-037: PRESETn low for 1 cycle during WAIT -> IDLE, LOCKCNT=0, outputs 20/1/2.
